// File: rtl/fir_pkg.sv
// Shared FIR defaults and width helpers for fir_filter_pipe, its bench and later FIR variants.
package fir_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_TAPS   = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Room for TAPS full-width products to add without overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + clog2(taps);
    endfunction

    localparam int DEF_ACC_W = acc_width(DEF_DATA_W, DEF_COEF_W, DEF_TAPS);

endpackage

// File: rtl/fir_delay_line.sv
// N-deep sample history for the FIR; taps[0] is the most recent accepted sample.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                flush,
    input  logic [W-1:0]        din,
    output logic [N-1:0][W-1:0] taps
);

    // Shift in a new sample on enable; flush wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (flush) begin
            taps <= '0;
        end else if (en) begin
            taps[0] <= din;
            for (int i = 1; i < N; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/fir_filter_pipe.sv
// Three-stage pipelined direct-form FIR (multiply, sum, round/shift) with loadable coefficients.
// Define FIR_SAT_EN to clamp the result to the output range instead of wrapping it.
module fir_filter_pipe
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int SHIFT  = COEF_W - 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     flush,
    input  logic                     coef_we,
    input  logic [clog2(TAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        data_out
);

    localparam int AW    = clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam logic signed [ACC_W-1:0] RND = (SHIFT > 0) ? (ACC_W'(1) << (SHIFT - 1)) : '0;

    logic [TAPS-2:0][DATA_W-1:0] x_s;
    logic signed [DATA_W-1:0]    tap_s  [TAPS];
    logic signed [COEF_W-1:0]    coef_r [TAPS];
    logic signed [PW-1:0]        p_r    [TAPS];
    logic signed [ACC_W-1:0]     sum_s;
    logic signed [ACC_W-1:0]     acc_r;
    logic [DATA_W-1:0]           res_s;
    logic                        v1_r;
    logic                        v2_r;

    fir_delay_line #(
        .N (TAPS - 1),
        .W (DATA_W)
    ) u_delay (
        .clk   (clk),
        .rst_n (reset),
        .en    (in_valid),
        .flush (flush),
        .din   (data_in),
        .taps  (x_s)
    );

    // Tap 0 sees the incoming sample directly, the rest come from history.
    always_comb begin
        tap_s[0] = $signed(data_in);
        for (int i = 1; i < TAPS; i++) begin
            tap_s[i] = $signed(x_s[i-1]);
        end
    end

    // Coefficient bank; an out-of-range address matches no tap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                if (coef_we && (coef_addr == AW'(i))) begin
                    coef_r[i] <= coef_data;
                end
            end
        end
    end

    // Stage 1: full-precision products, sampled with the pre-write coefficients.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                p_r[i] <= '0;
            end
            v1_r <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < TAPS; i++) begin
                p_r[i] <= '0;
            end
            v1_r <= 1'b0;
        end else begin
            v1_r <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < TAPS; i++) begin
                    p_r[i] <= PW'(tap_s[i]) * PW'(coef_r[i]);
                end
            end
        end
    end

    // Adder tree input: sign-extended sum of all products.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum_s = sum_s + ACC_W'(p_r[i]);
        end
    end

    // Stage 2: accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r <= '0;
            v2_r  <= 1'b0;
        end else if (flush) begin
            acc_r <= '0;
            v2_r  <= 1'b0;
        end else begin
            acc_r <= sum_s;
            v2_r  <= v1_r;
        end
    end

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] shr_s;

    // Round half up, scale, then clamp to the output range.
    always_comb begin
        shr_s = (acc_r + RND) >>> SHIFT;
        if (shr_s > SAT_MAX) begin
            res_s = SAT_MAX[DATA_W-1:0];
        end else if (shr_s < SAT_MIN) begin
            res_s = SAT_MIN[DATA_W-1:0];
        end else begin
            res_s = shr_s[DATA_W-1:0];
        end
    end
`else
    // Round half up, scale, keep the low DATA_W bits.
    always_comb begin
        res_s = DATA_W'((acc_r + RND) >>> SHIFT);
    end
`endif

    // Stage 3: output register; data_out holds through bubbles and flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= v2_r;
            if (v2_r) begin
                data_out <= res_s;
            end
        end
    end

endmodule
